lap_timer_ctrl: RTL and testbench

LAP_TIMER_CTRL -- requirements
Module: lap_timer_ctrl

---
 rtl/lap_timer_ctrl_if.sv | 36 +++
 rtl/lap_timer_ctrl.sv | 111 +++++++++++
 tb/tb_lap_timer_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lap_timer_ctrl_if.sv
// Signal bundle between the lap timer controller, the stopwatch counter and the SSD path.
// slave is the controller side; master is the side that drives buttons, ticks and live time.
interface lap_timer_ctrl_if;
    logic       tick_1hz;
    logic       pause_start;
    logic       lap_reset;
    logic [3:0] live_min_tens;
    logic [3:0] live_min_units;
    logic [3:0] live_sec_tens;
    logic [3:0] live_sec_units;
    logic [1:0] state;
    logic       count_en;
    logic       count_clr;
    logic [3:0] disp_min_tens;
    logic [3:0] disp_min_units;
    logic [3:0] disp_sec_tens;
    logic [3:0] disp_sec_units;
    logic [3:0] lap_cnt;
    logic       limit_hit;

    modport slave (
        input  tick_1hz, pause_start, lap_reset,
        input  live_min_tens, live_min_units, live_sec_tens, live_sec_units,
        output state, count_en, count_clr,
        output disp_min_tens, disp_min_units, disp_sec_tens, disp_sec_units,
        output lap_cnt, limit_hit
    );

    modport master (
        output tick_1hz, pause_start, lap_reset,
        output live_min_tens, live_min_units, live_sec_tens, live_sec_units,
        input  state, count_en, count_clr,
        input  disp_min_tens, disp_min_units, disp_sec_tens, disp_sec_units,
        input  lap_cnt, limit_hit
    );
endinterface

// File: rtl/lap_timer_ctrl.sv
// Stopwatch sequencing FSM: run/pause/lap control, lap capture and display mux, 59:59 stop.
//  state | meaning
//  IDLE  | counter held clear, lap count and limit flag cleared
//  COUNT | counting, display live
//  PAUSE | counting halted, display live
//  LAP   | counting, display frozen on captured lap time
module lap_timer_ctrl #(
    parameter int LAP_CNT_MAX = 9
) (
    input  logic clk,
    input  logic rst_n,
    lap_timer_ctrl_if.slave ctrl
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [3:0] LAP_MAX = 4'(LAP_CNT_MAX);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] lap_reg;
    logic [3:0]  lap_cnt_q;
    logic        limit_hit_q;
    logic [15:0] live;
    logic        at_limit;
    logic        running;
    logic        limit_trip;
    logic        capture;
    logic        enter_idle;

    assign live       = {ctrl.live_min_tens, ctrl.live_min_units,
                         ctrl.live_sec_tens, ctrl.live_sec_units};
    assign at_limit   = (live == 16'h5959);
    assign running    = (state_q == COUNT) || (state_q == LAP);
    assign limit_trip = ctrl.tick_1hz && running && at_limit;
    assign capture    = (state_q == COUNT) && (state_d == LAP);
    assign enter_idle = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A limit trip overrides any button pulse in the same cycle so the stop is never missed.
    always_comb begin
        state_d = state_q;
        if (limit_trip) begin
            state_d = PAUSE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ctrl.pause_start) state_d = COUNT;
                end
                COUNT: begin
                    if (ctrl.pause_start)    state_d = PAUSE;
                    else if (ctrl.lap_reset) state_d = LAP;
                end
                LAP: begin
                    if (ctrl.pause_start)    state_d = PAUSE;
                    else if (ctrl.lap_reset) state_d = COUNT;
                end
                PAUSE: begin
                    if (ctrl.pause_start) begin
                        if (!at_limit) state_d = COUNT;
                    end else if (ctrl.lap_reset) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_reg     <= 16'h0000;
            lap_cnt_q   <= 4'd0;
            limit_hit_q <= 1'b0;
        end else begin
            if (capture) begin
                lap_reg <= live;
            end
            if (enter_idle) begin
                lap_cnt_q <= 4'd0;
            end else if (capture && (lap_cnt_q < LAP_MAX)) begin
                lap_cnt_q <= lap_cnt_q + 4'd1;
            end
            if (enter_idle) begin
                limit_hit_q <= 1'b0;
            end else if (limit_trip) begin
                limit_hit_q <= 1'b1;
            end
        end
    end

    assign ctrl.state     = state_q;
    assign ctrl.count_en  = ctrl.tick_1hz && running && !at_limit;
    assign ctrl.count_clr = (state_q == IDLE);
    assign ctrl.lap_cnt   = lap_cnt_q;
    assign ctrl.limit_hit = limit_hit_q;

    assign {ctrl.disp_min_tens, ctrl.disp_min_units,
            ctrl.disp_sec_tens, ctrl.disp_sec_units} = (state_q == LAP) ? lap_reg : live;
endmodule

// File: tb/tb_lap_timer_ctrl.sv
// Directed bench for lap_timer_ctrl with hand-computed expectations (LAP_CNT_MAX=2).
module tb_lap_timer_ctrl;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_LAP   = 2'd3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lap_timer_ctrl_if bus ();

    lap_timer_ctrl #(.LAP_CNT_MAX(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] disp_word();
        return {bus.disp_min_tens, bus.disp_min_units, bus.disp_sec_tens, bus.disp_sec_units};
    endfunction

    task automatic set_live(input logic [15:0] v);
        {bus.live_min_tens, bus.live_min_units, bus.live_sec_tens, bus.live_sec_units} = v;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'(S_IDLE));
        check({tag, "_en"},    32'(bus.count_en), 32'd0);
        check({tag, "_clr"},   32'(bus.count_clr), 32'd1);
        check({tag, "_lapcnt"},32'(bus.lap_cnt), 32'd0);
        check({tag, "_limit"}, 32'(bus.limit_hit), 32'd0);
        check({tag, "_disp"},  32'(disp_word()), 32'(1'b0 ? 16'h0 : {bus.live_min_tens, bus.live_min_units, bus.live_sec_tens, bus.live_sec_units}));
    endtask

    // Drive one cycle of inputs, check count_en before the edge, then check the new state.
    task automatic step(input string tag, input logic ps, input logic lr, input logic tk,
                        input logic exp_en, input logic [1:0] exp_state);
        @(negedge clk);
        bus.pause_start = ps;
        bus.lap_reset   = lr;
        bus.tick_1hz    = tk;
        #1;
        check({tag, "_en"}, 32'(bus.count_en), 32'(exp_en));
        @(posedge clk);
        #1;
        bus.pause_start = 1'b0;
        bus.lap_reset   = 1'b0;
        bus.tick_1hz    = 1'b0;
        check({tag, "_state"}, 32'(bus.state), 32'(exp_state));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.pause_start = 1'b0;
        bus.lap_reset   = 1'b0;
        bus.tick_1hz    = 1'b0;
        set_live(16'h1234);
        #3;
        check_reset_values("rst");
        check("rst_disp_live", 32'(disp_word()), 32'h1234);
        @(negedge clk);
        rst_n = 1'b1;

        // Start and count three seconds
        set_live(16'h0000);
        step("start", 1'b1, 1'b0, 1'b0, 1'b0, S_COUNT);
        check("start_clr", 32'(bus.count_clr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("tick%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, S_COUNT);
        end

        // Lap capture and freeze
        set_live(16'h0123);
        step("lap", 1'b0, 1'b1, 1'b0, 1'b0, S_LAP);
        check("lap_cnt1", 32'(bus.lap_cnt), 32'd1);
        check("lap_disp", 32'(disp_word()), 32'h0123);
        step("lap_tick", 1'b0, 1'b0, 1'b1, 1'b1, S_LAP);
        set_live(16'h0124);
        #1;
        check("lap_frozen", 32'(disp_word()), 32'h0123);
        step("unlap", 1'b0, 1'b1, 1'b0, 1'b0, S_COUNT);
        check("unlap_disp", 32'(disp_word()), 32'h0124);

        // Simultaneous buttons with tick: pause wins, tick uses COUNT
        step("both", 1'b1, 1'b1, 1'b1, 1'b1, S_PAUSE);
        check("both_lapcnt", 32'(bus.lap_cnt), 32'd1);
        check("pause_disp", 32'(disp_word()), 32'h0124);
        step("pause_tick", 1'b0, 1'b0, 1'b1, 1'b0, S_PAUSE);

        // Limit stop at 59:59
        step("resume", 1'b1, 1'b0, 1'b0, 1'b0, S_COUNT);
        set_live(16'h5959);
        step("limit", 1'b0, 1'b0, 1'b1, 1'b0, S_PAUSE);
        check("limit_hit", 32'(bus.limit_hit), 32'd1);
        step("limit_nostart", 1'b1, 1'b0, 1'b0, 1'b0, S_PAUSE);
        check("limit_sticky", 32'(bus.limit_hit), 32'd1);

        // Back to IDLE clears lap count and limit
        step("to_idle", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE);
        check("idle_clr", 32'(bus.count_clr), 32'd1);
        check("idle_lapcnt", 32'(bus.lap_cnt), 32'd0);
        check("idle_limit", 32'(bus.limit_hit), 32'd0);
        step("idle_lr", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE);

        // Lap counter saturation at 2
        set_live(16'h0100);
        step("sat_start", 1'b1, 1'b0, 1'b0, 1'b0, S_COUNT);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("sat_lap%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, S_LAP);
            check($sformatf("sat_cnt%0d", i), 32'(bus.lap_cnt), (i == 0) ? 32'd1 : 32'd2);
            if (i < 3) begin
                step($sformatf("sat_back%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, S_COUNT);
            end
        end

        // Asynchronous reset in LAP with a pulse present
        @(negedge clk);
        set_live(16'h0222);
        bus.pause_start = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        check("arst_disp_live", 32'(disp_word()), 32'h0222);
        @(posedge clk);
        #1;
        check("arst_discard", 32'(bus.state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.pause_start = 1'b0;
        check("first_pulse", 32'(bus.state), 32'(S_COUNT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
